// File: rtl/prog_ctr_rstack.sv
// prog_ctr_rstack
//   Fetch-stage program counter with a hardware return-address stack (RAS).
//   It supports relative/absolute branches, call/return, stall, and sticky
//   stack-error flags.
//
// Ports
//   Clk        clock, all state updates on posedge
//   Reset      synchronous active-high reset, overrides everything
//   En         program running; 0 holds all state
//   Stall      pipeline stall; 1 holds all state regardless of En
//   BranchEn   jump to Target
//   Call       push ProgCtr+1, jump to Target
//   Ret        pop RAS top into ProgCtr
//   Source     offset select: 0 = LUTin, 1 = RegIn (zero-extended)
//   Absolute   0 = Target is ProgCtr+offset, 1 = Target is offset
//   RegIn      register-sourced offset/address
//   LUTin      LUT-sourced offset/address
//   ProgCtr    program counter (instruction-ROM address)
//   SP         RAS occupancy, 0..DEPTH
//   Empty      SP == 0
//   Full       SP == DEPTH
//   Overflow   sticky: a Call was attempted while Full
//   Underflow  sticky: a Ret was attempted while Empty
module prog_ctr_rstack #(
  parameter  int unsigned PC_W  = 10,
  parameter  int unsigned REG_W = 8,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned SP_W  = $clog2(DEPTH + 1)
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             En,
  input  logic             Stall,
  input  logic             BranchEn,
  input  logic             Call,
  input  logic             Ret,
  input  logic             Source,
  input  logic             Absolute,
  input  logic [REG_W-1:0] RegIn,
  input  logic [PC_W-1:0]  LUTin,
  output logic [PC_W-1:0]  ProgCtr,
  output logic [SP_W-1:0]  SP,
  output logic             Empty,
  output logic             Full,
  output logic             Overflow,
  output logic             Underflow
);

  // Index width for the RAS array; a single-entry stack still needs one bit.
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SP_W-1:0] SP_MAX = SP_W'(DEPTH);

  logic [PC_W-1:0]  ras [DEPTH];

  logic             advance;
  logic [PC_W-1:0]  offset;
  logic [PC_W-1:0]  target;
  logic [PC_W-1:0]  pc_inc;
  logic [SP_W-1:0]  sp_dec;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] push_idx;
  logic             do_push;

  assign advance  = En & ~Stall;
  assign offset   = Source ? PC_W'(RegIn) : LUTin;
  assign target   = Absolute ? offset : (ProgCtr + offset);
  assign pc_inc   = ProgCtr + PC_W'(1);
  assign sp_dec   = SP - SP_W'(1);
  assign top_idx  = IDX_W'(sp_dec);
  assign push_idx = IDX_W'(SP);

  assign Empty = (SP == '0);
  assign Full  = (SP == SP_MAX);

  // Ret outranks Call, so a push only happens for a lone Call with room left.
  assign do_push = advance & ~Reset & Call & ~Ret & ~Full;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ProgCtr   <= '0;
      SP        <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else if (advance) begin
      if (Ret) begin
        if (!Empty) begin
          ProgCtr <= ras[top_idx];
          SP      <= sp_dec;
        end else begin
          ProgCtr   <= pc_inc;
          Underflow <= 1'b1;
        end
      end else if (Call) begin
        ProgCtr <= target;
        if (!Full) begin
          SP <= SP + SP_W'(1);
        end else begin
          Overflow <= 1'b1;
        end
      end else if (BranchEn) begin
        ProgCtr <= target;
      end else begin
        ProgCtr <= pc_inc;
      end
    end
  end

  // Stack storage is not reset: entries above SP are never read.
  always_ff @(posedge Clk) begin
    if (do_push) begin
      ras[push_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_prog_ctr_rstack.sv
module tb_prog_ctr_rstack;

  logic       Clk;
  logic       Reset;
  logic       En;
  logic       Stall;
  logic       BranchEn;
  logic       Call;
  logic       Ret;
  logic       Source;
  logic       Absolute;
  logic [7:0] RegIn;
  logic [9:0] LUTin;
  logic [9:0] ProgCtr;
  logic [2:0] SP;
  logic       Empty;
  logic       Full;
  logic       Overflow;
  logic       Underflow;

  int tests;
  int fails;

  prog_ctr_rstack #(.PC_W(10), .REG_W(8), .DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset), .En(En), .Stall(Stall), .BranchEn(BranchEn),
    .Call(Call), .Ret(Ret), .Source(Source), .Absolute(Absolute),
    .RegIn(RegIn), .LUTin(LUTin), .ProgCtr(ProgCtr), .SP(SP),
    .Empty(Empty), .Full(Full), .Overflow(Overflow), .Underflow(Underflow)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic ctl(input logic b, input logic c, input logic r,
                     input logic src, input logic abs_,
                     input logic [7:0] reg_v, input logic [9:0] lut_v);
    BranchEn = b; Call = c; Ret = r; Source = src; Absolute = abs_;
    RegIn = reg_v; LUTin = lut_v;
  endtask

  task automatic do_reset();
    Reset = 1'b1; En = 1'b0; Stall = 1'b0;
    ctl(0, 0, 0, 0, 0, 8'd0, 10'd0);
    tick();
    Reset = 1'b0; En = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (ProgCtr !== 10'd0) begin fails++; $display("FAIL reset_pc got %0d exp 0", ProgCtr); end
    tests++; if (SP !== 3'd0) begin fails++; $display("FAIL reset_sp got %0d exp 0", SP); end
    tests++; if ({Empty, Full} !== 2'b10) begin fails++; $display("FAIL reset_empty_full got %b exp 10", {Empty, Full}); end
    tests++; if ({Overflow, Underflow} !== 2'b00) begin fails++; $display("FAIL reset_flags got %b exp 00", {Overflow, Underflow}); end
    for (int i = 1; i <= 5; i++) begin
      tick();
      tests++; if (ProgCtr !== 10'(i)) begin fails++; $display("FAIL count_pc got %0d exp %0d", ProgCtr, i); end
    end
    tests++; if ({SP, Overflow, Underflow} !== 5'b000_00) begin fails++; $display("FAIL count_sp_flags got %b exp 00000", {SP, Overflow, Underflow}); end
  endtask

  task automatic test_call_ret();
    do_reset();
    ctl(1, 0, 0, 0, 1, 8'd0, 10'd8); tick();
    tests++; if (ProgCtr !== 10'd8) begin fails++; $display("FAIL cr_setup_pc got %0d exp 8", ProgCtr); end
    ctl(0, 1, 0, 0, 0, 8'd0, 10'd20); tick();
    tests++; if (ProgCtr !== 10'd28) begin fails++; $display("FAIL cr_call_pc got %0d exp 28", ProgCtr); end
    tests++; if (SP !== 3'd1) begin fails++; $display("FAIL cr_call_sp got %0d exp 1", SP); end
    ctl(0, 0, 1, 0, 0, 8'd0, 10'd0); tick();
    tests++; if (ProgCtr !== 10'd9) begin fails++; $display("FAIL cr_ret_pc got %0d exp 9", ProgCtr); end
    tests++; if (SP !== 3'd0) begin fails++; $display("FAIL cr_ret_sp got %0d exp 0", SP); end
  endtask

  task automatic test_nested_overflow();
    logic [9:0] tgt [5];
    logic [9:0] rets [4];
    tgt  = '{10'd100, 10'd200, 10'd300, 10'd400, 10'd500};
    rets = '{10'd301, 10'd201, 10'd101, 10'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      ctl(0, 1, 0, 0, 1, 8'd0, tgt[i]); tick();
      tests++; if (ProgCtr !== tgt[i]) begin fails++; $display("FAIL nest_call_pc[%0d] got %0d exp %0d", i, ProgCtr, tgt[i]); end
    end
    tests++; if (SP !== 3'd4) begin fails++; $display("FAIL nest_sp got %0d exp 4", SP); end
    tests++; if (Full !== 1'b1) begin fails++; $display("FAIL nest_full got %b exp 1", Full); end
    tests++; if (Overflow !== 1'b1) begin fails++; $display("FAIL nest_overflow got %b exp 1", Overflow); end
    for (int i = 0; i < 4; i++) begin
      ctl(0, 0, 1, 0, 0, 8'd0, 10'd0); tick();
      tests++; if (ProgCtr !== rets[i]) begin fails++; $display("FAIL nest_ret_pc[%0d] got %0d exp %0d", i, ProgCtr, rets[i]); end
      tests++; if (SP !== 3'(3 - i)) begin fails++; $display("FAIL nest_ret_sp[%0d] got %0d exp %0d", i, SP, 3 - i); end
    end
    tests++; if (Underflow !== 1'b0) begin fails++; $display("FAIL nest_no_underflow got %b exp 0", Underflow); end
    tick();
    tests++; if (ProgCtr !== 10'd2) begin fails++; $display("FAIL nest_under_pc got %0d exp 2", ProgCtr); end
    tests++; if ({SP, Empty} !== 4'b000_1) begin fails++; $display("FAIL nest_under_sp got %b exp 0001", {SP, Empty}); end
    tests++; if ({Overflow, Underflow} !== 2'b11) begin fails++; $display("FAIL nest_sticky got %b exp 11", {Overflow, Underflow}); end
    ctl(0, 0, 0, 0, 0, 8'd0, 10'd0); tick();
    tests++; if ({Overflow, Underflow} !== 2'b11) begin fails++; $display("FAIL nest_sticky_hold got %b exp 11", {Overflow, Underflow}); end
  endtask

  task automatic test_wrap();
    do_reset();
    ctl(1, 0, 0, 0, 0, 8'd0, 10'd1000); tick();
    tests++; if (ProgCtr !== 10'd1000) begin fails++; $display("FAIL rel_lut_pc got %0d exp 1000", ProgCtr); end
    ctl(1, 0, 0, 0, 1, 8'd0, 10'd1020); tick();
    tests++; if (ProgCtr !== 10'd1020) begin fails++; $display("FAIL wrap_setup_pc got %0d exp 1020", ProgCtr); end
    ctl(1, 0, 0, 1, 0, 8'd8, 10'd0); tick();
    tests++; if (ProgCtr !== 10'd4) begin fails++; $display("FAIL wrap_rel_pc got %0d exp 4", ProgCtr); end
    ctl(1, 0, 0, 1, 1, 8'h3F, 10'd0); tick();
    tests++; if (ProgCtr !== 10'd63) begin fails++; $display("FAIL abs_reg_pc got %0d exp 63", ProgCtr); end
    ctl(1, 0, 0, 1, 1, 8'hFF, 10'd0); tick();
    tests++; if (ProgCtr !== 10'd255) begin fails++; $display("FAIL zext_reg_pc got %0d exp 255", ProgCtr); end
    ctl(1, 0, 0, 0, 1, 8'd0, 10'd1023); tick();
    ctl(0, 0, 0, 0, 0, 8'd0, 10'd0); tick();
    tests++; if (ProgCtr !== 10'd0) begin fails++; $display("FAIL inc_wrap_pc got %0d exp 0", ProgCtr); end
  endtask

  task automatic test_stall();
    do_reset();
    tick(); tick();
    tests++; if (ProgCtr !== 10'd2) begin fails++; $display("FAIL stall_setup_pc got %0d exp 2", ProgCtr); end
    Stall = 1'b1;
    ctl(0, 1, 0, 0, 1, 8'd0, 10'd50);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if ({ProgCtr, SP} !== {10'd2, 3'd0}) begin fails++; $display("FAIL stall_hold[%0d] got pc %0d sp %0d exp pc 2 sp 0", i, ProgCtr, SP); end
    end
    Stall = 1'b0; tick();
    tests++; if ({ProgCtr, SP} !== {10'd50, 3'd1}) begin fails++; $display("FAIL stall_release got pc %0d sp %0d exp pc 50 sp 1", ProgCtr, SP); end
    ctl(0, 0, 0, 0, 0, 8'd0, 10'd0); tick();
    tests++; if (ProgCtr !== 10'd51) begin fails++; $display("FAIL stall_next_pc got %0d exp 51", ProgCtr); end
    ctl(0, 0, 1, 0, 0, 8'd0, 10'd0); tick();
    tests++; if ({ProgCtr, SP} !== {10'd3, 3'd0}) begin fails++; $display("FAIL stall_ret got pc %0d sp %0d exp pc 3 sp 0", ProgCtr, SP); end
    En = 1'b0; tick(); tick();
    tests++; if ({ProgCtr, SP, Underflow} !== {10'd3, 3'd0, 1'b0}) begin fails++; $display("FAIL en_low_hold got pc %0d sp %0d uf %b exp pc 3 sp 0 uf 0", ProgCtr, SP, Underflow); end
    En = 1'b1;
  endtask

  task automatic test_back_to_back();
    do_reset();
    ctl(0, 1, 0, 0, 1, 8'd0, 10'd40); tick();
    tests++; if ({ProgCtr, SP} !== {10'd40, 3'd1}) begin fails++; $display("FAIL b2b_call got pc %0d sp %0d exp pc 40 sp 1", ProgCtr, SP); end
    ctl(0, 1, 1, 0, 1, 8'd0, 10'd77); tick();
    tests++; if ({ProgCtr, SP} !== {10'd1, 3'd0}) begin fails++; $display("FAIL callret_pop got pc %0d sp %0d exp pc 1 sp 0", ProgCtr, SP); end
    tests++; if ({Overflow, Underflow} !== 2'b00) begin fails++; $display("FAIL callret_flags got %b exp 00", {Overflow, Underflow}); end
    ctl(1, 0, 1, 0, 1, 8'd0, 10'd500); tick();
    tests++; if ({ProgCtr, Underflow} !== {10'd2, 1'b1}) begin fails++; $display("FAIL retbr_under got pc %0d uf %b exp pc 2 uf 1", ProgCtr, Underflow); end
    Reset = 1'b1;
    ctl(0, 1, 0, 0, 1, 8'd0, 10'd300); tick();
    tests++; if ({ProgCtr, SP, Overflow, Underflow} !== {10'd0, 3'd0, 2'b00}) begin fails++; $display("FAIL reset_call got pc %0d sp %0d flags %b exp pc 0 sp 0 flags 00", ProgCtr, SP, {Overflow, Underflow}); end
    Reset = 1'b0;
    ctl(0, 0, 1, 0, 0, 8'd0, 10'd0); tick();
    tests++; if ({ProgCtr, SP, Underflow} !== {10'd1, 3'd0, 1'b1}) begin fails++; $display("FAIL reset_no_push got pc %0d sp %0d uf %b exp pc 1 sp 0 uf 1", ProgCtr, SP, Underflow); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_call_ret();
    test_nested_overflow();
    test_wrap();
    test_stall();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
